// File: rtl/mine_placer.sv
// mine_placer: LFSR-driven mine-field generator.
// Places MINES distinct mines on a COLS x ROWS board, skipping the safe cell.
module mine_placer #(
  parameter int COLS  = 16,
  parameter int ROWS  = 16,
  parameter int MINES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] entropy,
  input  logic        start,
  input  logic [3:0]  safe_x,
  input  logic [3:0]  safe_y,
  input  logic [3:0]  rd_x,
  input  logic [3:0]  rd_y,
  output logic        rd_mine,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mine_count
);

  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    GEN,
    FIN
  } state_t;

  state_t          state;
  logic [15:0]     seed;
  logic [15:0]     lfsr;
  logic [3:0]      sx;
  logic [3:0]      sy;
  logic [N-1:0]    bitmap;

  logic [3:0]      cx;
  logic [3:0]      cy;
  logic            c_in;
  logic            c_safe;
  logic [IW-1:0]   c_idx;
  logic            accept;
  logic            last;
  logic [15:0]     lfsr_nx;
  logic            rd_in;
  logic [IW-1:0]   rd_idx;

  assign cx      = lfsr[3:0];
  assign cy      = lfsr[7:4];
  assign c_in    = (int'(cx) < COLS) && (int'(cy) < ROWS);
  assign c_safe  = (cx == sx) && (cy == sy);
  assign c_idx   = IW'(int'(cy) * COLS + int'(cx));
  assign accept  = c_in && !c_safe && !bitmap[c_idx];
  assign last    = (mine_count == 8'(MINES - 1));
  assign lfsr_nx = {1'b0, lfsr[15:1]}
                 ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Out-of-board reads return 0 regardless of bitmap contents.
  assign rd_in   = (int'(rd_x) < COLS) && (int'(rd_y) < ROWS);
  assign rd_idx  = IW'(int'(rd_y) * COLS + int'(rd_x));
  assign rd_mine = rd_in ? bitmap[rd_idx] : 1'b0;

  // Control FSM, LFSR and bitmap; reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mine_count <= 8'd0;
      bitmap     <= '0;
      lfsr       <= 16'h0001;
      seed       <= 16'h0000;
      sx         <= 4'd0;
      sy         <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            seed       <= entropy;
            sx         <= safe_x;
            sy         <= safe_y;
            bitmap     <= '0;
            mine_count <= 8'd0;
            busy       <= 1'b1;
            state      <= SEED;
          end
        end
        SEED: begin
          lfsr  <= (seed == 16'h0000) ? 16'h0001 : seed;
          state <= GEN;
        end
        GEN: begin
          lfsr <= lfsr_nx;
          if (accept) begin
            bitmap[c_idx] <= 1'b1;
            mine_count    <= mine_count + 8'd1;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: scoreboard bench for mine_placer.
// Four instances cover 16x16 with 1/2/40 mines and a 5x3 board.
module tb_mine_placer;

  typedef struct {
    logic [255:0] bm;
    int           lat;
    int           cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] entropy;
  logic [3:0]  safe_x;
  logic [3:0]  safe_y;
  logic [3:0]  rd_x;
  logic [3:0]  rd_y;
  logic [3:0]  start_v;
  logic [3:0]  rdm_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [7:0]  cnt_v [4];

  int cols_t [4]  = '{16, 16, 16, 5};
  int rows_t [4]  = '{16, 16, 16, 3};
  int mines_t [4] = '{1, 2, 40, 14};

  exp_t sb [$];
  int   total;
  int   bad;

  mine_placer #(.COLS(16), .ROWS(16), .MINES(1)) u_m0 (
    .clk(clk), .rst(rst), .entropy(entropy), .start(start_v[0]),
    .safe_x(safe_x), .safe_y(safe_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_mine(rdm_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .mine_count(cnt_v[0])
  );

  mine_placer #(.COLS(16), .ROWS(16), .MINES(2)) u_m1 (
    .clk(clk), .rst(rst), .entropy(entropy), .start(start_v[1]),
    .safe_x(safe_x), .safe_y(safe_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_mine(rdm_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .mine_count(cnt_v[1])
  );

  mine_placer u_m2 (
    .clk(clk), .rst(rst), .entropy(entropy), .start(start_v[2]),
    .safe_x(safe_x), .safe_y(safe_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_mine(rdm_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .mine_count(cnt_v[2])
  );

  mine_placer #(.COLS(5), .ROWS(3), .MINES(14)) u_m3 (
    .clk(clk), .rst(rst), .entropy(entropy), .start(start_v[3]),
    .safe_x(safe_x), .safe_y(safe_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_mine(rdm_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .mine_count(cnt_v[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int cols, input int rows,
                       input int mines, input logic [15:0] sd,
                       input logic [3:0] x, input logic [3:0] y,
                       output exp_t e);
    logic [15:0]  l;
    logic [3:0]   cx;
    logic [3:0]   cy;
    logic [255:0] bm;
    int           n;
    int           g;
    int           k;
    l  = (sd == 16'h0) ? 16'h0001 : sd;
    bm = '0;
    n  = 0;
    g  = 0;
    while (n < mines && g < 70000) begin
      cx = l[3:0];
      cy = l[7:4];
      k  = int'(cy) * 16 + int'(cx);
      g++;
      if (int'(cx) < cols && int'(cy) < rows &&
          !(cx == x && cy == y) && !bm[k]) begin
        bm[k] = 1'b1;
        n++;
      end
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
    e.bm  = bm;
    e.lat = 3 + g;
    e.cnt = n;
  endtask

  task automatic sweep(input int w, output logic [255:0] v);
    v = '0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        rd_x = 4'(x);
        rd_y = 4'(y);
        #1;
        v[y*16+x] = rdm_v[w];
      end
    end
  endtask

  task automatic run(input int w, input logic [15:0] sd,
                     input logic [3:0] x, input logic [3:0] y,
                     input bit poke,
                     output logic [255:0] v, output int lat);
    exp_t e;
    exp_t g;
    int   berr;
    int   dn;
    model(cols_t[w], rows_t[w], mines_t[w], sd, x, y, e);
    sb.push_back(e);
    @(posedge clk); #1;
    entropy    = sd;
    safe_x     = x;
    safe_y     = y;
    start_v[w] = 1'b1;
    @(posedge clk); #1;
    start_v[w] = 1'b0;
    lat  = 2;
    berr = busy_v[w] ? 0 : 1;
    dn   = 0;
    while (!done_v[w] && lat < e.lat + 5) begin
      if (poke && lat == 6) begin
        start_v[w] = 1'b1;
        entropy    = ~sd;
        safe_x     = 4'd0;
        safe_y     = 4'd0;
      end else begin
        start_v[w] = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (!done_v[w] && !busy_v[w]) berr++;
    end
    start_v[w] = 1'b0;
    if (done_v[w]) begin
      dn = 1;
      if (busy_v[w]) berr++;
      @(posedge clk); #1;
      if (done_v[w]) dn++;
    end
    g = sb.pop_front();
    sweep(w, v);
    check("bitmap", v, g.bm);
    check("count", cnt_v[w], g.cnt);
    check("latency", lat, g.lat);
    check("busy", berr, 0);
    check("done_pulse", dn, 1);
  endtask

  initial begin
    logic [255:0] v;
    logic [255:0] ex;
    logic [15:0]  rs;
    int           lat;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    entropy = 16'h0;
    safe_x  = 4'd0;
    safe_y  = 4'd0;
    rd_x    = 4'd0;
    rd_y    = 4'd0;
    start_v = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int w = 0; w < 4; w++) begin
      sweep(w, v);
      check("rst_map", v, 0);
      check("rst_cnt", cnt_v[w], 0);
      check("rst_busy", busy_v[w], 0);
      check("rst_done", done_v[w], 0);
    end

    run(0, 16'h0000, 4'd0, 4'd0, 1'b0, v, lat);
    check("t1_map", v, 256'h2);
    check("t1_lat", lat, 4);

    run(1, 16'h0000, 4'd0, 4'd0, 1'b0, v, lat);
    check("t2_safe", v[0], 0);
    check("t2_first", v[1], 1);

    rs = 16'($urandom);
    run(2, rs, 4'd7, 4'd7, 1'b1, v, lat);
    check("t3_pop", $countones(v), 40);
    check("t3_safe", v[7*16+7], 0);

    run(3, 16'hACE1, 4'd4, 4'd2, 1'b0, v, lat);
    ex = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 5; x++)
        if (!(x == 4 && y == 2)) ex[y*16+x] = 1'b1;
    check("t4_map", v, ex);

    run(3, 16'h0F0F, 4'd9, 4'd9, 1'b0, v, lat);

    @(posedge clk); #1;
    entropy    = 16'hBEEF;
    safe_x     = 4'd7;
    safe_y     = 4'd7;
    start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("ab_busy", busy_v[2], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("ab_cnt", cnt_v[2], 0);
    check("ab_idle", busy_v[2], 0);
    sweep(2, v);
    check("ab_map", v, 0);

    run(2, 16'h1234, 4'd7, 4'd7, 1'b0, v, lat);
    check("re_safe", v[7*16+7], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
# mine_placer

Randomised mine-field generator for the minesweeper game. It takes the 16-bit entropy word from the ring-oscillator counter as a seed, runs a 16-bit Galois LFSR, and places exactly MINES mines on a COLS×ROWS board. It never places a mine twice and never on the player's first-click cell. It owns the mine bitmap and gives the game logic a combinational per-cell read port.

## Interface
- COLS, default 16: board width, 1..16.
- ROWS, default 16: board height, 1..16.
- MINES, default 40: number of mines, 1..COLS*ROWS-1.
- clk  in  1: system clock.
- rst  in  1: synchronous, active-high reset.
- entropy  in  16: seed word from the ring-oscillator counter, sampled on start.
- start  in  1: one-cycle request to generate a board; ignored unless IDLE.
- safe_x  in  4: column excluded from placement, sampled on start.
- safe_y  in  4: row excluded from placement, sampled on start.
- rd_x  in  4: read column.
- rd_y  in  4: read row.
- rd_mine  out  1: combinational; 1 if the cell (rd_x, rd_y) holds a mine; 0 if rd_x>=COLS or rd_y>=ROWS.
- busy  out  1: high from the cycle after start through the last placement cycle.
- done  out  1: one-cycle pulse when the board is complete.
- mine_count  out  8: number of mines placed so far.

## Operation
- States: IDLE, SEED, GEN, FIN.
- IDLE:
  - On start=1: capture entropy, safe_x and safe_y; clear all bitmap bits; set mine_count=0; go to SEED.
- SEED:
  - lfsr <= entropy, or 16'h0001 if entropy==0 (the all-zero state is forbidden).
  - Go to GEN.
- GEN, every cycle:
  - Candidate cell: cx=lfsr[3:0], cy=lfsr[7:4].
  - Accept when cx<COLS, cy<ROWS, (cx,cy)!=(safe_x,safe_y), and the bit is not already set. On accept: set the bit and increment mine_count.
  - lfsr advances every GEN cycle, accepted or not: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 16'h0000).
  - If an accept makes mine_count==MINES, go to FIN on the next edge.
- FIN:
  - done=1 for exactly this cycle, then return to IDLE.
  - The bitmap holds its contents until the next start or rst.
- Termination:
  - The LFSR is maximal-length, so every low-byte value recurs within 65535 steps.
  - Every legal cell is therefore reachable and generation always terminates.
- Bitmap: COLS*ROWS bits, index cy*COLS+cx.
  - rd_mine is a pure combinational read.
  - rd_mine shows partial contents while busy.
- start while busy, or during FIN, is ignored. Held inputs are not re-sampled.
- Out-of-range safe_x/safe_y: no cell is excluded and generation proceeds normally.

## Timing
- Reset values: state=IDLE, busy=0, done=0, mine_count=0, all bitmap bits 0, lfsr=16'h0001.
- rst wins over all other activity. It aborts generation mid-run and clears the bitmap on the same edge.
- Cycle sequence after start is sampled at edge T:
  - Edge T: enter SEED.
  - Edge T+1: lfsr seeded, enter GEN.
  - First candidate evaluated in cycle T+2.
  - busy=1 from cycle T+1 through the final GEN cycle; busy=0 in FIN.
- Latency = 2 + (number of GEN cycles) + 1 cycles from start to done. Minimum is MINES+3.
- mine_count updates on the same edge that sets the corresponding bitmap bit.

## Test plan
- Reset and read-back: assert rst for 2 cycles, then sweep rd_x/rd_y over all cells.
  - Required: rd_mine=0 everywhere, mine_count=0, busy=0, done=0.
- Zero-seed substitution and safe-cell exclusion: entropy=0, safe=(0,0), MINES=1.
  - lfsr=0x0001 gives (1,0), which is accepted.
  - Required: done 4 cycles after start; only cell (1,0) set; mine_count=1.
- Duplicate and safe-cell rejection: entropy=0, safe=(0,0), MINES=2.
  - Sequence: 0x0001 gives (1,0), accepted. 0xB400 gives (0,0), rejected as the safe cell. 0x5A00 gives (0,0), rejected. 0x2D00 gives (0,0), rejected.
  - Continue against a golden LFSR model.
  - Required: bitmap matches the model exactly; (0,0) never set.
- Full default board: random entropy, safe=(7,7), defaults 16×16/40.
  - Required: exactly 40 bits set, (7,7) clear, mine_count=40, a single done pulse.
  - Bitmap and latency match the golden model.
- Small board rejection: COLS=5, ROWS=3, MINES=14, safe=(4,2).
  - Required: every cell except (4,2) set; nothing set outside 5×3; rd_mine=0 for rd_x=5.
- Abort and re-trigger:
  - Assert start again while busy. Required: ignored.
  - Assert rst mid-GEN. Required: bitmap cleared and IDLE on the next edge.
  - Start again with entropy=0x1234. Required: result matches the model for that seed.
